// File: rtl/rf_wb_arbiter_if.sv
// Write-port bundle between the two result producers, the arbiter and the register file.
// Optional RAW pending-write query ports exist only when RF_WB_PEND_EN is defined.
interface rf_wb_arbiter_if #(
    parameter int DEPTH = 4
);
    logic                    alu_valid;
    logic                    alu_ready;
    logic [4:0]              alu_addr;
    logic [31:0]             alu_data;
    logic                    ls_valid;
    logic                    ls_ready;
    logic [4:0]              ls_addr;
    logic [31:0]             ls_data;
    logic                    rf_we;
    logic [4:0]              rf_waddr;
    logic [31:0]             rf_wdata;
    logic [$clog2(DEPTH):0]  fifo_cnt;
`ifdef RF_WB_PEND_EN
    logic [4:0]              q1_addr;
    logic [4:0]              q2_addr;
    logic                    q1_pend;
    logic                    q2_pend;

    modport master (
        output alu_valid, alu_addr, alu_data, ls_valid, ls_addr, ls_data, q1_addr, q2_addr,
        input  alu_ready, ls_ready, rf_we, rf_waddr, rf_wdata, fifo_cnt, q1_pend, q2_pend
    );
    modport slave (
        input  alu_valid, alu_addr, alu_data, ls_valid, ls_addr, ls_data, q1_addr, q2_addr,
        output alu_ready, ls_ready, rf_we, rf_waddr, rf_wdata, fifo_cnt, q1_pend, q2_pend
    );
`else
    modport master (
        output alu_valid, alu_addr, alu_data, ls_valid, ls_addr, ls_data,
        input  alu_ready, ls_ready, rf_we, rf_waddr, rf_wdata, fifo_cnt
    );
    modport slave (
        input  alu_valid, alu_addr, alu_data, ls_valid, ls_addr, ls_data,
        output alu_ready, ls_ready, rf_we, rf_waddr, rf_wdata, fifo_cnt
    );
`endif
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write arbiter: ALU results have priority, long-latency results wait in a FIFO
// bounded by a starvation counter. RF_WB_PEND_EN adds pending-write lookups for RAW stalls.
module rf_wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic             clk,
    input  logic             rst,
    rf_wb_arbiter_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_ALU,
        GNT_FIFO,
        GNT_STARVE
    } grant_t;

    logic [4:0]    addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [SW-1:0] starve_cnt;

    logic          rf_we_q;
    logic [4:0]    rf_waddr_q;
    logic [31:0]   rf_wdata_q;

    grant_t        grant;
    logic          fifo_empty;
    logic          fifo_full;
    logic          starve;
    logic          push;
    logic          pop;
    logic [4:0]    gnt_addr;
    logic [31:0]   gnt_data;

    assign fifo_empty = (cnt == '0);
    assign fifo_full  = (cnt == CW'(DEPTH));
    assign starve     = !fifo_empty && (starve_cnt == SW'(STARVE_MAX));

    // ls_ready looks only at full, so a pop in the same cycle never makes room for a push.
    assign push = bus.ls_valid && !fifo_full;
    assign pop  = (grant == GNT_STARVE) || (grant == GNT_FIFO);

    always_comb begin
        grant    = GNT_IDLE;
        gnt_addr = 5'd0;
        gnt_data = 32'd0;
        if (starve) begin
            grant    = GNT_STARVE;
            gnt_addr = addr_mem[rd_ptr];
            gnt_data = data_mem[rd_ptr];
        end else if (bus.alu_valid) begin
            grant    = GNT_ALU;
            gnt_addr = bus.alu_addr;
            gnt_data = bus.alu_data;
        end else if (!fifo_empty) begin
            grant    = GNT_FIFO;
            gnt_addr = addr_mem[rd_ptr];
            gnt_data = data_mem[rd_ptr];
        end
    end

    // Storage needs no reset: only entries inside the rd_ptr..cnt window are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= bus.ls_addr;
            data_mem[wr_ptr] <= bus.ls_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (pop || fifo_empty) begin
            starve_cnt <= '0;
        end else if ((grant == GNT_ALU) && (starve_cnt != SW'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Writes to $0 are consumed here but never raise rf_we on the port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'd0;
        end else if (grant != GNT_IDLE) begin
            rf_we_q    <= (gnt_addr != 5'd0);
            rf_waddr_q <= gnt_addr;
            rf_wdata_q <= gnt_data;
        end else begin
            rf_we_q    <= 1'b0;
        end
    end

    assign bus.alu_ready = !starve;
    assign bus.ls_ready  = !fifo_full;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.fifo_cnt  = cnt;

`ifdef RF_WB_PEND_EN
    function automatic logic pend_hit(input logic [4:0] q);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < cnt) && (addr_mem[rd_ptr + AW'(k)] == q)) hit = 1'b1;
        end
        if (rf_we_q && (rf_waddr_q == q)) hit = 1'b1;
        return hit && (q != 5'd0);
    endfunction

    always_comb begin
        bus.q1_pend = pend_hit(bus.q1_addr);
        bus.q2_pend = pend_hit(bus.q2_addr);
    end
`else
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: a table of single-cycle vectors plus hand-written
// sequences for FIFO wrap and starvation; expected writes flow through a scoreboard queue.
module tb_rf_wb_arbiter;

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        ardy;
        logic        lrdy;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [2:0]  cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t sb[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.DEPTH(4)) bus ();

    rf_wb_arbiter #(.DEPTH(4), .STARVE_MAX(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                input logic lv, input logic [4:0] la, input logic [31:0] ld,
                                input logic ardy, input logic lrdy, input logic we,
                                input logic [4:0] waddr, input logic [31:0] wdata,
                                input logic [2:0] cnt);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad; v.lv = lv; v.la = la; v.ld = ld;
        v.ardy = ardy; v.lrdy = lrdy; v.we = we; v.waddr = waddr; v.wdata = wdata; v.cnt = cnt;
        return v;
    endfunction

    task automatic compareValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        else n_pass++;
    endtask

    // Drive one cycle of inputs, check the combinational handshakes, queue the expected write.
    task automatic applyStimulus(input vec_t v);
        bus.alu_valid = v.av;
        bus.alu_addr  = v.aa;
        bus.alu_data  = v.ad;
        bus.ls_valid  = v.lv;
        bus.ls_addr   = v.la;
        bus.ls_data   = v.ld;
        #1;
        compareValue("alu_ready", 32'(bus.alu_ready), 32'(v.ardy));
        compareValue("ls_ready", 32'(bus.ls_ready), 32'(v.lrdy));
        sb.push_back(v);
    endtask

    task automatic checkOutput();
        vec_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            compareValue("scoreboard_empty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            compareValue("rf_we", 32'(bus.rf_we), 32'(e.we));
            if (e.we) begin
                compareValue("rf_waddr", 32'(bus.rf_waddr), 32'(e.waddr));
                compareValue("rf_wdata", bus.rf_wdata, e.wdata);
            end
            compareValue("fifo_cnt", 32'(bus.fifo_cnt), 32'(e.cnt));
        end
    endtask

    task automatic runVec(input vec_t v);
        applyStimulus(v);
        checkOutput();
    endtask

    initial begin
        bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
        bus.ls_valid  = 1'b0; bus.ls_addr  = '0; bus.ls_data  = '0;
`ifdef RF_WB_PEND_EN
        bus.q1_addr = 5'd0;
        bus.q2_addr = 5'd0;
`endif

        // Reset held low for two edges while the producers toggle randomly.
        for (int i = 0; i < 2; i++) begin
            bus.alu_valid = 1'($urandom); bus.alu_addr = 5'($urandom); bus.alu_data = $urandom;
            bus.ls_valid  = 1'($urandom); bus.ls_addr  = 5'($urandom); bus.ls_data  = $urandom;
            @(posedge clk);
            #1;
            compareValue("reset_rf_we", 32'(bus.rf_we), 32'd0);
            compareValue("reset_rf_waddr", 32'(bus.rf_waddr), 32'd0);
            compareValue("reset_rf_wdata", bus.rf_wdata, 32'd0);
            compareValue("reset_fifo_cnt", 32'(bus.fifo_cnt), 32'd0);
        end
        bus.alu_valid = 1'b0;
        bus.ls_valid  = 1'b0;
        rst = 1'b1;

        // av aa ad lv la ld | ardy lrdy | we waddr wdata cnt
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 1, 1, 5, 32'hDEADBEEF, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 32'h1234, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 32'h5555, 1, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3, 32'hA3, 1, 9, 32'hB9, 1, 1, 1, 3, 32'hA3, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 9, 32'hB9, 0));
        vecs.push_back(mk(0, 0, 0, 1, 10, 32'hC10, 1, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 11, 32'hC11, 1, 1, 1, 10, 32'hC10, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 11, 32'hC11, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        for (int i = 0; i < vecs.size(); i++) runVec(vecs[i]);

        // FIFO fill with ALU busy, full refusal, then drain in order across the pointer wrap.
        runVec(mk(1, 20, 32'hD20, 1, 1, 32'hF1, 1, 1, 1, 20, 32'hD20, 1));
        runVec(mk(1, 21, 32'hD21, 1, 2, 32'hF2, 1, 1, 1, 21, 32'hD21, 2));
        runVec(mk(1, 22, 32'hD22, 1, 3, 32'hF3, 1, 1, 1, 22, 32'hD22, 3));
        runVec(mk(1, 23, 32'hD23, 1, 4, 32'hF4, 1, 1, 1, 23, 32'hD23, 4));
        runVec(mk(0, 0, 0, 1, 5, 32'hF5, 0, 0, 1, 1, 32'hF1, 3));
        runVec(mk(0, 0, 0, 1, 5, 32'hF5, 1, 1, 1, 2, 32'hF2, 3));
        runVec(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 3, 32'hF3, 2));
        runVec(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 4, 32'hF4, 1));
        runVec(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 5, 32'hF5, 0));
        runVec(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));

        // Starvation: three ALU wins, then the head is forced out and the ALU holds its result.
        runVec(mk(0, 0, 0, 1, 12, 32'hE12, 1, 1, 0, 0, 0, 1));
        runVec(mk(1, 13, 32'hA13, 0, 0, 0, 1, 1, 1, 13, 32'hA13, 1));
        runVec(mk(1, 14, 32'hA14, 0, 0, 0, 1, 1, 1, 14, 32'hA14, 1));
        runVec(mk(1, 15, 32'hA15, 0, 0, 0, 1, 1, 1, 15, 32'hA15, 1));
        runVec(mk(1, 16, 32'hA16, 0, 0, 0, 0, 1, 1, 12, 32'hE12, 0));
        runVec(mk(1, 16, 32'hA16, 0, 0, 0, 1, 1, 1, 16, 32'hA16, 0));
        runVec(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));

`ifdef RF_WB_PEND_EN
        bus.q1_addr = 5'd7;
        bus.q2_addr = 5'd8;
        runVec(mk(0, 0, 0, 1, 7, 32'h77, 1, 1, 0, 0, 0, 1));
        compareValue("q1_pend_fifo", 32'(bus.q1_pend), 32'd1);
        compareValue("q2_pend_fifo", 32'(bus.q2_pend), 32'd0);
        runVec(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 7, 32'h77, 0));
        compareValue("q1_pend_out", 32'(bus.q1_pend), 32'd1);
        runVec(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        compareValue("q1_pend_clear", 32'(bus.q1_pend), 32'd0);
        compareValue("q2_pend_clear", 32'(bus.q2_pend), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
